tot_multi_trigger: RTL

//  Parametrised Time-over-Threshold (ToT/ToTd) station trigger for NCH PMT channels.

---
 rtl/tot_multi_trigger.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/tot_multi_trigger.sv
// tot_multi_trigger
//   Time-over-Threshold station trigger for NCH PMT channels. Per-channel
//   sample and integral streams arrive at the full CLK120 rate. The trigger
//   logic advances once every DOWNSAMPLE clocks, on the strobe cycle.
//
//   Pipeline, one stage per strobe:
//     S1  register ADC / INTEGRAL / THRES / UP
//     S2  per-channel hit: THRES < ADC <= UP, gated by TRIG_ENABLE
//     S3  sliding window of hits plus a running occupancy count
//     S4  per-channel qualified flag (occupancy and integral both above limit)
//     S5  multiplicity / holdoff decision, rising-edge pulse on TRIG
//
//   The block has no handshakes. Inputs are sampled on every strobe, and
//   outputs are registered.
//
// Ports
//   CLK120        clock, rising edge
//   RESET         synchronous, active-high
//   ADC           NCH*ADC_W samples, channel i at [i*ADC_W +: ADC_W]
//   INTEGRAL      NCH*INT_W running integrals, same packing
//   THRES         NCH*ADC_W lower threshold (exclusive)
//   UP            NCH*ADC_W upper limit (inclusive)
//   TRIG_ENABLE   NCH per-channel enable
//   MULTIPLICITY  channels required, 0 disables the trigger
//   OCCUPANCY     occupancy must exceed this value
//   INT           integral must exceed this value
//   HOLDOFF       strobes blocked after a trigger
//   TRIG          one-CLK120-cycle trigger pulse
//   SB_STATUS     per-channel qualified flag
module tot_multi_trigger #(
  parameter int NCH        = 3,
  parameter int ADC_W      = 12,
  parameter int INT_W      = 19,
  parameter int WIDTH      = 120,
  parameter int OCC_W      = 8,
  parameter int DOWNSAMPLE = 3,
  parameter int HOLD_W     = 8
) (
  input  logic                 CLK120,
  input  logic                 RESET,
  input  logic [NCH*ADC_W-1:0] ADC,
  input  logic [NCH*INT_W-1:0] INTEGRAL,
  input  logic [NCH*ADC_W-1:0] THRES,
  input  logic [NCH*ADC_W-1:0] UP,
  input  logic [NCH-1:0]       TRIG_ENABLE,
  input  logic [3:0]           MULTIPLICITY,
  input  logic [OCC_W-1:0]     OCCUPANCY,
  input  logic [INT_W-1:0]     INT,
  input  logic [HOLD_W-1:0]    HOLDOFF,
  output logic                 TRIG,
  output logic [NCH-1:0]       SB_STATUS
);

  localparam int PH_W = 2;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(DOWNSAMPLE - 1);

  logic [PH_W-1:0]             phase;
  logic                        strobe;

  logic [NCH-1:0][ADC_W-1:0]   s1_adc, s1_thr, s1_up;
  logic [NCH-1:0][INT_W-1:0]   s1_int, s2_int, s3_int;
  logic [NCH-1:0]              hit_c, hit;
  logic [NCH-1:0][WIDTH-1:0]   win;
  logic [NCH-1:0][OCC_W-1:0]   occ;
  logic [NCH-1:0]              sb;
  logic [HOLD_W-1:0]           hold;
  logic                        cond, cond_prev;
  logic [3:0]                  pop;
  logic                        trig_r;

  assign strobe = (phase == '0);

  always_comb begin
    hit_c = '0;
    for (int i = 0; i < NCH; i++) begin
      hit_c[i] = (s1_thr[i] < s1_adc[i]) && (s1_adc[i] <= s1_up[i]) && TRIG_ENABLE[i];
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < NCH; i++) begin
      pop = pop + {3'b000, sb[i]};
    end
    cond = (pop >= MULTIPLICITY) && (MULTIPLICITY != 4'd0) && (hold == '0);
  end

  always_ff @(posedge CLK120) begin
    if (RESET) begin
      phase     <= '0;
      s1_adc    <= '0;
      s1_thr    <= '0;
      s1_up     <= '0;
      s1_int    <= '0;
      s2_int    <= '0;
      s3_int    <= '0;
      hit       <= '0;
      win       <= '0;
      occ       <= '0;
      sb        <= '0;
      hold      <= '0;
      cond_prev <= 1'b0;
      trig_r    <= 1'b0;
    end else begin
      // TRIG is a single CLK120 cycle wide even when DOWNSAMPLE > 1.
      trig_r <= 1'b0;
      phase  <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
      if (strobe) begin
        for (int i = 0; i < NCH; i++) begin
          s1_adc[i] <= ADC[i*ADC_W +: ADC_W];
          s1_thr[i] <= THRES[i*ADC_W +: ADC_W];
          s1_up[i]  <= UP[i*ADC_W +: ADC_W];
          s1_int[i] <= INTEGRAL[i*INT_W +: INT_W];
          s2_int[i] <= s1_int[i];
          s3_int[i] <= s2_int[i];
          sb[i]     <= (occ[i] > OCCUPANCY) && (s3_int[i] > INT);
        end
        hit       <= hit_c;
        cond_prev <= cond;
        trig_r    <= cond && !cond_prev;
        if (cond) begin
          // A trigger clears every window, overriding this strobe's shift.
          win  <= '0;
          occ  <= '0;
          hold <= HOLDOFF;
        end else begin
          if (hold != '0) hold <= hold - HOLD_W'(1);
          for (int i = 0; i < NCH; i++) begin
            win[i] <= {win[i][WIDTH-2:0], hit[i]};
            // The count tracks the window contents exactly, so it stays
            // within 0..WIDTH without any saturation logic.
            if (hit[i] && !win[i][WIDTH-1])
              occ[i] <= occ[i] + OCC_W'(1);
            else if (!hit[i] && win[i][WIDTH-1])
              occ[i] <= occ[i] - OCC_W'(1);
          end
        end
      end
    end
  end

  assign TRIG      = trig_r;
  assign SB_STATUS = sb;

endmodule
